// File: rtl/of_pkg.sv
// Shared widths and the ID/EX operand bundle type for the operand-fetch stage.
package of_pkg;

   localparam int DATA_W   = 16;
   localparam int ADDR_W   = 4;
   localparam int NUM_REGS = 2 ** ADDR_W;

   localparam int          STALL_W   = 16;
   localparam logic [15:0] STALL_MAX = 16'hFFFF;

   // Operand bundle handed from decode/fetch to execute
   typedef struct packed {
      logic [3:0]        op;
      logic [ADDR_W-1:0] rd;
      logic              wr_en;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
   } id_ex_t;

endpackage

// File: rtl/of_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set when an
// instruction that writes the register is accepted and cleared by writeback.
module of_scoreboard
   import of_pkg::*;
#(
   parameter int SB_ADDR_W = of_pkg::ADDR_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  set_en,
   input  logic [SB_ADDR_W-1:0]  set_reg,
   input  logic                  clr_en,
   input  logic [SB_ADDR_W-1:0]  clr_reg,
   input  logic [SB_ADDR_W-1:0]  rs1,
   input  logic [SB_ADDR_W-1:0]  rs2,
   output logic                  hazard1,
   output logic                  hazard2
);

   localparam int SB_REGS = 2 ** SB_ADDR_W;

   logic [SB_REGS-1:0] pending_q;
   logic [SB_REGS-1:0] pending_d;

   // A source is only a hazard if its writeback is not arriving this very
   // cycle; the same-cycle writeback is forwarded by the bypass instead.
   always_comb begin
      hazard1 = pending_q[rs1] && !(clr_en && (clr_reg == rs1));
      hazard2 = pending_q[rs2] && !(clr_en && (clr_reg == rs2));
   end

   // Clear first, then set, so a new writer to the same register keeps it pending
   always_comb begin
      pending_d = pending_q;
      if (clr_en) begin
         pending_d[clr_reg] = 1'b0;
      end
      if (set_en) begin
         pending_d[set_reg] = 1'b1;
      end
   end

   // Pending vector register, wiped asynchronously by reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
      end
   end

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: reads the register file, forwards same-cycle
// writeback data, stalls on read-after-write hazards and registers the
// operand bundle toward execute behind a valid/ready handshake.
module operand_fetch
#(
   parameter int DATA_W = of_pkg::DATA_W,
   parameter int ADDR_W = of_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_op,
   input  logic [ADDR_W-1:0] in_rs1,
   input  logic [ADDR_W-1:0] in_rs2,
   input  logic [ADDR_W-1:0] in_rd,
   input  logic              in_wr_en,
   output logic [ADDR_W-1:0] rf_read_reg1,
   output logic [ADDR_W-1:0] rf_read_reg2,
   input  logic [DATA_W-1:0] rf_reg1_data,
   input  logic [DATA_W-1:0] rf_reg2_data,
   input  logic              wb_valid,
   input  logic [ADDR_W-1:0] wb_reg,
   input  logic [DATA_W-1:0] wb_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [3:0]        out_op,
   output logic [ADDR_W-1:0] out_rd,
   output logic              out_wr_en,
   output logic [DATA_W-1:0] out_a,
   output logic [DATA_W-1:0] out_b,
   output logic [15:0]       stall_cycles
);

   import of_pkg::*;

   // Local bundle type sized by this instance's parameters
   typedef struct packed {
      logic [3:0]        op;
      logic [ADDR_W-1:0] rd;
      logic              wr_en;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
   } bundle_t;

   logic              hazard1;
   logic              hazard2;
   logic              raw_hazard;
   logic              accept;
   logic [DATA_W-1:0] opnd_a;
   logic [DATA_W-1:0] opnd_b;

   bundle_t           bundle_q;
   bundle_t           bundle_d;
   logic              out_valid_q;
   logic              out_valid_d;
   logic [15:0]       stall_q;
   logic [15:0]       stall_d;

   // Register-file reads follow the decoded sources directly
   always_comb begin
      rf_read_reg1 = in_rs1;
      rf_read_reg2 = in_rs2;
   end

   // Hazards are judged on the pre-update scoreboard, so rd==rs never self-stalls
   of_scoreboard #(
      .SB_ADDR_W (ADDR_W)
   ) u_scoreboard (
      .clk     (clk),
      .reset   (reset),
      .set_en  (accept && in_wr_en),
      .set_reg (in_rd),
      .clr_en  (wb_valid),
      .clr_reg (wb_reg),
      .rs1     (in_rs1),
      .rs2     (in_rs2),
      .hazard1 (hazard1),
      .hazard2 (hazard2)
   );

   // Handshake: accept only when the output slot frees up and no source is stale
   always_comb begin
      raw_hazard = in_valid && (hazard1 || hazard2);
      in_ready   = (!out_valid_q || out_ready) && !raw_hazard;
      accept     = in_valid && in_ready;
   end

   // Same-cycle writeback bypass takes priority over the register file read
   always_comb begin
      opnd_a = rf_reg1_data;
      opnd_b = rf_reg2_data;
      if (wb_valid && (wb_reg == in_rs1)) begin
         opnd_a = wb_data;
      end
      if (wb_valid && (wb_reg == in_rs2)) begin
         opnd_b = wb_data;
      end
   end

   // Output slot: load on accept, drain on consume, otherwise hold
   always_comb begin
      bundle_d    = bundle_q;
      out_valid_d = out_valid_q;
      if (accept) begin
         bundle_d.op    = in_op;
         bundle_d.rd    = in_rd;
         bundle_d.wr_en = in_wr_en;
         bundle_d.a     = opnd_a;
         bundle_d.b     = opnd_b;
         out_valid_d    = 1'b1;
      end else if (out_ready) begin
         out_valid_d    = 1'b0;
      end
   end

   // Count cycles where an instruction waits, pinning at the maximum
   always_comb begin
      stall_d = stall_q;
      if (in_valid && !in_ready && (stall_q != STALL_MAX)) begin
         stall_d = stall_q + 16'd1;
      end
   end

   // State registers, all cleared asynchronously by reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bundle_q    <= '0;
         out_valid_q <= 1'b0;
         stall_q     <= '0;
      end else begin
         bundle_q    <= bundle_d;
         out_valid_q <= out_valid_d;
         stall_q     <= stall_d;
      end
   end

   // Drive the registered bundle onto the ports
   always_comb begin
      out_valid    = out_valid_q;
      out_op       = bundle_q.op;
      out_rd       = bundle_q.rd;
      out_wr_en    = bundle_q.wr_en;
      out_a        = bundle_q.a;
      out_b        = bundle_q.b;
      stall_cycles = stall_q;
   end

endmodule

// File: tb/tb_operand_fetch.sv
// Testbench for operand_fetch: directed scenarios followed by randomized
// traffic, all checked against a cycle-level behavioural model.
module tb_operand_fetch;

   import of_pkg::*;

   logic              clk = 1'b0;
   logic              reset;
   logic              in_valid;
   logic              in_ready;
   logic [3:0]        in_op;
   logic [ADDR_W-1:0] in_rs1;
   logic [ADDR_W-1:0] in_rs2;
   logic [ADDR_W-1:0] in_rd;
   logic              in_wr_en;
   logic [ADDR_W-1:0] rf_read_reg1;
   logic [ADDR_W-1:0] rf_read_reg2;
   logic [DATA_W-1:0] rf_reg1_data;
   logic [DATA_W-1:0] rf_reg2_data;
   logic              wb_valid;
   logic [ADDR_W-1:0] wb_reg;
   logic [DATA_W-1:0] wb_data;
   logic              out_valid;
   logic              out_ready;
   logic [3:0]        out_op;
   logic [ADDR_W-1:0] out_rd;
   logic              out_wr_en;
   logic [DATA_W-1:0] out_a;
   logic [DATA_W-1:0] out_b;
   logic [15:0]       stall_cycles;

   // Behavioural register file, written by the same writeback events
   logic [DATA_W-1:0] rfMem [NUM_REGS];

   // Reference model state
   logic                mValid;
   id_ex_t              mBundle;
   logic [NUM_REGS-1:0] mPending;
   int                  mStall;

   int totalCount = 0;
   int badCount   = 0;

   always #5 clk = ~clk;

   assign rf_reg1_data = rfMem[rf_read_reg1];
   assign rf_reg2_data = rfMem[rf_read_reg2];

   operand_fetch #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_op        (in_op),
      .in_rs1       (in_rs1),
      .in_rs2       (in_rs2),
      .in_rd        (in_rd),
      .in_wr_en     (in_wr_en),
      .rf_read_reg1 (rf_read_reg1),
      .rf_read_reg2 (rf_read_reg2),
      .rf_reg1_data (rf_reg1_data),
      .rf_reg2_data (rf_reg2_data),
      .wb_valid     (wb_valid),
      .wb_reg       (wb_reg),
      .wb_data      (wb_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_op       (out_op),
      .out_rd       (out_rd),
      .out_wr_en    (out_wr_en),
      .out_a        (out_a),
      .out_b        (out_b),
      .stall_cycles (stall_cycles)
   );

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      totalCount++;
      if (observed !== expected) begin
         badCount++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drive one cycle's worth of inputs
   task automatic applyStimulus(input logic v, input logic [3:0] op,
                                input logic [ADDR_W-1:0] rs1, input logic [ADDR_W-1:0] rs2,
                                input logic [ADDR_W-1:0] rd, input logic wr,
                                input logic wbv, input logic [ADDR_W-1:0] wbr,
                                input logic [DATA_W-1:0] wbd, input logic ordy);
      in_valid  = v;
      in_op     = op;
      in_rs1    = rs1;
      in_rs2    = rs2;
      in_rd     = rd;
      in_wr_en  = wr;
      wb_valid  = wbv;
      wb_reg    = wbr;
      wb_data   = wbd;
      out_ready = ordy;
   endtask

   task automatic modelReset();
      mValid   = 1'b0;
      mBundle  = '0;
      mPending = '0;
      mStall   = 0;
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      checkOutput({tag, "_out_op"}, 32'(out_op), 32'd0);
      checkOutput({tag, "_out_rd"}, 32'(out_rd), 32'd0);
      checkOutput({tag, "_out_wr_en"}, 32'(out_wr_en), 32'd0);
      checkOutput({tag, "_out_a"}, 32'(out_a), 32'd0);
      checkOutput({tag, "_out_b"}, 32'(out_b), 32'd0);
      checkOutput({tag, "_stall"}, 32'(stall_cycles), 32'd0);
      checkOutput({tag, "_pending"}, 32'(dut.u_scoreboard.pending_q), 32'd0);
   endtask

   // One clock: check at the falling edge, then advance the model past the rising edge
   task automatic runCycle();
      logic                hz1;
      logic                hz2;
      logic                expReady;
      logic                accept;
      logic                nValid;
      id_ex_t              nBundle;
      logic [NUM_REGS-1:0] nPending;
      int                  nStall;

      @(negedge clk);
      hz1 = mPending[in_rs1] && !(wb_valid && (wb_reg == in_rs1));
      hz2 = mPending[in_rs2] && !(wb_valid && (wb_reg == in_rs2));
      expReady = (!mValid || out_ready) && !(in_valid && (hz1 || hz2));

      checkOutput("in_ready", 32'(in_ready), 32'(expReady));
      checkOutput("rf_read_reg1", 32'(rf_read_reg1), 32'(in_rs1));
      checkOutput("rf_read_reg2", 32'(rf_read_reg2), 32'(in_rs2));
      checkOutput("out_valid", 32'(out_valid), 32'(mValid));
      if (mValid) begin
         checkOutput("out_op", 32'(out_op), 32'(mBundle.op));
         checkOutput("out_rd", 32'(out_rd), 32'(mBundle.rd));
         checkOutput("out_wr_en", 32'(out_wr_en), 32'(mBundle.wr_en));
         checkOutput("out_a", 32'(out_a), 32'(mBundle.a));
         checkOutput("out_b", 32'(out_b), 32'(mBundle.b));
      end
      checkOutput("stall_cycles", 32'(stall_cycles), 32'(mStall));
      checkOutput("pending", 32'(dut.u_scoreboard.pending_q), 32'(mPending));

      accept  = in_valid && expReady;
      nValid  = mValid;
      nBundle = mBundle;
      if (accept) begin
         nValid        = 1'b1;
         nBundle.op    = in_op;
         nBundle.rd    = in_rd;
         nBundle.wr_en = in_wr_en;
         nBundle.a     = (wb_valid && (wb_reg == in_rs1)) ? wb_data : rfMem[in_rs1];
         nBundle.b     = (wb_valid && (wb_reg == in_rs2)) ? wb_data : rfMem[in_rs2];
      end else if (out_ready) begin
         nValid = 1'b0;
      end
      nPending = mPending;
      if (wb_valid) nPending[wb_reg] = 1'b0;
      if (accept && in_wr_en) nPending[in_rd] = 1'b1;
      nStall = mStall;
      if (in_valid && !expReady && (mStall < 65535)) nStall = mStall + 1;

      @(posedge clk);
      #1;
      mValid   = nValid;
      mBundle  = nBundle;
      mPending = nPending;
      mStall   = nStall;
      if (wb_valid) rfMem[wb_reg] = wb_data;
   endtask

   initial begin
      for (int i = 0; i < NUM_REGS; i++) begin
         rfMem[i] = DATA_W'($urandom);
      end
      reset = 1'b0;
      applyStimulus(1'b0, 4'h0, '0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
      modelReset();

      // Held in reset: everything reads zero
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkResetOutputs("in_reset");
      @(posedge clk);
      #1;
      reset = 1'b1;

      // First cycle after release with an idle writeback to r1
      applyStimulus(1'b0, 4'h0, '0, '0, '0, 1'b0, 1'b1, 4'd1, 16'h00A5, 1'b1);
      runCycle();
      checkResetOutputs("post_release");

      // Writer of r2, then a reader of r2 that must wait
      applyStimulus(1'b1, 4'h3, 4'd0, 4'd1, 4'd2, 1'b1, 1'b0, '0, '0, 1'b1);
      runCycle();
      checkOutput("pending2_set", 32'(dut.u_scoreboard.pending_q[2]), 32'd1);
      applyStimulus(1'b1, 4'h5, 4'd2, 4'd0, 4'd4, 1'b0, 1'b0, '0, '0, 1'b1);
      repeat (3) runCycle();
      checkOutput("stall_after_three", 32'(stall_cycles), 32'd3);

      // Writeback of r2 arrives while stalled: accept with bypassed data
      applyStimulus(1'b1, 4'h5, 4'd2, 4'd0, 4'd4, 1'b0, 1'b1, 4'd2, 16'h1234, 1'b1);
      runCycle();
      checkOutput("bypass_out_a", 32'(out_a), 32'h1234);
      checkOutput("pending2_clear", 32'(dut.u_scoreboard.pending_q[2]), 32'd0);

      // Downstream backpressure for three cycles, then back-to-back reloads
      applyStimulus(1'b1, 4'h7, 4'd6, 4'd7, 4'd8, 1'b0, 1'b0, '0, '0, 1'b0);
      repeat (3) runCycle();
      checkOutput("held_op", 32'(out_op), 32'h5);
      applyStimulus(1'b1, 4'h7, 4'd6, 4'd7, 4'd8, 1'b0, 1'b0, '0, '0, 1'b1);
      runCycle();
      checkOutput("reload_valid", 32'(out_valid), 32'd1);
      checkOutput("reload_op", 32'(out_op), 32'h7);
      applyStimulus(1'b1, 4'h9, 4'd1, 4'd6, 4'd9, 1'b0, 1'b0, '0, '0, 1'b1);
      runCycle();
      checkOutput("second_reload_op", 32'(out_op), 32'h9);

      // Set and clear of r3 collide: set wins
      applyStimulus(1'b1, 4'hA, 4'd0, 4'd0, 4'd3, 1'b1, 1'b0, '0, '0, 1'b1);
      runCycle();
      applyStimulus(1'b1, 4'hB, 4'd0, 4'd1, 4'd3, 1'b1, 1'b1, 4'd3, 16'hBEEF, 1'b1);
      runCycle();
      checkOutput("pending3_kept", 32'(dut.u_scoreboard.pending_q[3]), 32'd1);

      // Reset mid-operation with a held bundle and r5 pending
      applyStimulus(1'b1, 4'hC, 4'd0, 4'd1, 4'd5, 1'b1, 1'b0, '0, '0, 1'b1);
      runCycle();
      applyStimulus(1'b0, 4'h0, '0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
      runCycle();
      checkOutput("pre_reset_valid", 32'(out_valid), 32'd1);
      checkOutput("pre_reset_pending5", 32'(dut.u_scoreboard.pending_q[5]), 32'd1);
      @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("async_reset_valid", 32'(out_valid), 32'd0);
      checkOutput("async_reset_pending", 32'(dut.u_scoreboard.pending_q), 32'd0);
      modelReset();
      @(posedge clk);
      #1;
      reset = 1'b1;

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         applyStimulus(1'($urandom_range(0, 3) != 0), 4'($urandom),
                       ADDR_W'($urandom), ADDR_W'($urandom), ADDR_W'($urandom),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       ADDR_W'($urandom), DATA_W'($urandom),
                       1'($urandom_range(0, 3) != 0));
         runCycle();
      end

      $display("test done: total=%0d bad=%0d", totalCount, badCount);
      $finish;
   end

endmodule
